// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle restoring divider with saturating quotient
//
// Divides a 2N-bit dividend by an N-bit divisor, one quotient bit per clock.
// If the quotient cannot fit in N bits, the fast path saturates it.
// Divide-by-zero also takes the fast path.
//
// Ports:
//   clk       rising-edge clock
//   r         asynchronous active-low reset
//   start     request, sampled only while idle
//   dividend  2N-bit numerator, captured on the accepted start edge
//   divisor   N-bit denominator, captured on the accepted start edge
//   q         N-bit quotient (registered, saturates to all ones on overflow)
//   rem       N-bit remainder (registered)
//   busy      high while an operation is in progress (RUN or DONE)
//   done      one-cycle pulse when q, rem and of are valid
//   of        overflow / divide-by-zero flag (registered)
module seq_divider #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           r,
    input  logic           start,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic [N-1:0]   q,
    output logic [N-1:0]   rem,
    output logic           busy,
    output logic           done,
    output logic           of
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    // The partial remainder is always below the divisor between iterations.
    // Its conceptual (N+1)th bit is therefore always zero and is not stored.
    logic [N-1:0]  r_q, r_d;
    logic [N-1:0]  sh_q, sh_d;
    logic [N-1:0]  d_q, d_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  q_q, q_d;
    logic [N-1:0]  rem_q, rem_d;
    logic          of_q, of_d;

    logic [N-1:0]  hi, lo;
    logic [N:0]    shifted;
    logic          ge;
    logic [N-1:0]  r_next;
    logic [N-1:0]  sh_next;

    assign hi = dividend[2*N-1:N];
    assign lo = dividend[N-1:0];

    // One restoring step: bring in the next dividend bit, then try to subtract D.
    // When the subtraction succeeds, the result is below D.
    // Modulo-2^N arithmetic on the low N bits is then exact.
    assign shifted = {r_q, sh_q[N-1]};
    assign ge      = (shifted >= {1'b0, d_q});
    assign r_next  = ge ? (shifted[N-1:0] - d_q) : shifted[N-1:0];
    assign sh_next = {sh_q[N-2:0], ge};

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        sh_d    = sh_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        rem_d   = rem_q;
        of_d    = of_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    d_d = divisor;
                    // H >= D means the quotient needs more than N bits.
                    if ((divisor == '0) || (hi >= divisor)) begin
                        state_d = DONE;
                        q_d     = '1;
                        rem_d   = '0;
                        of_d    = 1'b1;
                    end else begin
                        state_d = RUN;
                        r_d     = hi;
                        sh_d    = lo;
                        cnt_d   = CW'(N);
                        of_d    = 1'b0;
                    end
                end
            end
            RUN: begin
                r_d   = r_next;
                sh_d  = sh_next;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    q_d     = sh_next;
                    rem_d   = r_next;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state_q <= IDLE;
            r_q     <= '0;
            sh_q    <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            rem_q   <= '0;
            of_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            sh_q    <= sh_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            rem_q   <= rem_d;
            of_q    <= of_d;
        end
    end

    assign q    = q_q;
    assign rem  = rem_q;
    assign of   = of_q;
    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider
module tb_seq_divider;

    localparam int N = 8;

    logic           clk;
    logic           r;
    logic           start;
    logic [2*N-1:0] dividend;
    logic [N-1:0]   divisor;
    logic [N-1:0]   q;
    logic [N-1:0]   rem;
    logic           busy;
    logic           done;
    logic           of;

    seq_divider #(.N(N)) dut (
        .clk      (clk),
        .r        (r),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .q        (q),
        .rem      (rem),
        .busy     (busy),
        .done     (done),
        .of       (of)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     nm, act, act, exp, exp, $time);
        end
    endtask

    // Behavioural model: edge count, accept edge, latency and arithmetic result.
    // After edge k the cycle index is k.
    // An operation accepted at edge a is busy in cycles a .. a+lat-1.
    // Done is high in cycle a+lat-1.
    int         cyc   = 0;
    int         acc   = -100;
    int         lat   = 1;
    int         n_acc = 0;
    logic [7:0] mq    = '0;
    logic [7:0] mrem  = '0;
    logic       mof   = 1'b0;

    always @(posedge clk or negedge r) begin
        if (!r) begin
            acc  = -100;
            lat  = 1;
            mq   = '0;
            mrem = '0;
            mof  = 1'b0;
        end else begin
            int hh;
            int dd;
            int full;
            cyc++;
            if (start && !((cyc - 1 >= acc) && (cyc - 1 <= acc + lat - 1))) begin
                full = int'(dividend);
                dd   = int'(divisor);
                hh   = full / 256;
                acc  = cyc;
                n_acc++;
                if (dd == 0 || hh >= dd) begin
                    lat  = 1;
                    mq   = 8'hFF;
                    mrem = 8'h00;
                    mof  = 1'b1;
                end else begin
                    lat  = N + 1;
                    mq   = 8'(full / dd);
                    mrem = 8'(full % dd);
                    mof  = 1'b0;
                end
            end
        end
    end

    // Per-cycle compare against the model.
    // The result outputs are only meaningful when idle or on the done pulse.
    always @(negedge clk) begin
        if (r) begin
            bit bexp;
            bit dexp;
            bexp = (cyc >= acc) && (cyc <= acc + lat - 1);
            dexp = (cyc == acc + lat - 1);
            chk("m_busy", int'(busy), int'(bexp));
            chk("m_done", int'(done), int'(dexp));
            if (!bexp || dexp) begin
                chk("m_q", int'(q), int'(mq));
                chk("m_rem", int'(rem), int'(mrem));
                chk("m_of", int'(of), int'(mof));
            end
        end
    end

    task automatic run_op(input logic [15:0] dvd, input logic [7:0] dvs,
                          input int eq, input int erem, input int eof,
                          input int elat, input bit mid);
        int k;
        int nb;
        bit got;
        @(negedge clk);
        dividend = dvd;
        divisor  = dvs;
        start    = 1'b1;
        k   = 0;
        nb  = 0;
        got = 1'b0;
        while (!got && k < 40) begin
            @(negedge clk);
            k++;
            if (busy) nb++;
            if (done) got = 1'b1;
            if (mid && k == 3) begin
                start    = 1'b1;
                dividend = 16'h0FFF;
                divisor  = 8'h01;
            end else begin
                start    = 1'b0;
                dividend = 16'($urandom);
                divisor  = 8'($urandom);
            end
        end
        chk("op_done_seen", int'(got), 1);
        chk("op_latency", k, elat);
        chk("op_busy_cycles", nb, elat);
        chk("op_q", int'(q), eq);
        chk("op_rem", int'(rem), erem);
        chk("op_of", int'(of), eof);
        start = 1'b0;
        @(negedge clk);
        chk("op_done_one_cycle", int'(done), 0);
        chk("op_idle_after", int'(busy), 0);
        chk("op_q_hold", int'(q), eq);
    endtask

    initial begin
        int dones;
        int k;
        int target;
        r        = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        chk("rst_q", int'(q), 0);
        chk("rst_rem", int'(rem), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_of", int'(of), 0);
        r = 1'b1;

        run_op(16'h03E8, 8'h07, 142, 6, 0, N + 1, 1'b0);
        run_op(16'h1234, 8'h56, 54, 16, 0, N + 1, 1'b1);
        run_op(16'h06FF, 8'h07, 255, 6, 0, N + 1, 1'b0);
        run_op(16'h0700, 8'h07, 255, 0, 1, 1, 1'b0);
        run_op(16'h0100, 8'h00, 255, 0, 1, 1, 1'b0);
        run_op(16'h00FF, 8'hFF, 1, 0, 0, N + 1, 1'b0);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        dividend = 16'h7FFE;
        divisor  = 8'hFF;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        r = 1'b0;
        #1;
        chk("arst_q", int'(q), 0);
        chk("arst_rem", int'(rem), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_of", int'(of), 0);
        @(negedge clk);
        r = 1'b1;
        run_op(16'h0064, 8'h0A, 10, 0, 0, N + 1, 1'b0);

        // start held high: one acceptance per idle visit.
        @(negedge clk);
        dividend = 16'h03E8;
        divisor  = 8'h07;
        start    = 1'b1;
        dones    = 0;
        for (int i = 0; i < 3 * (N + 2); i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        start = 1'b0;
        chk("b2b_done_count", dones, 3);
        k = 0;
        while (busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("b2b_drain", int'(busy), 0);

        // Random back-to-back operations with start held high.
        target = n_acc + 1000;
        k = 0;
        while (n_acc < target && k < 20000) begin
            int sel;
            int dsv;
            int hv;
            @(negedge clk);
            k++;
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      dsv = 1;
            else if (sel == 1) dsv = 255;
            else if (sel == 2) dsv = 0;
            else               dsv = int'($urandom_range(1, 255));
            if (dsv > 0 && $urandom_range(0, 9) < 8) hv = int'($urandom_range(0, dsv - 1));
            else                                     hv = int'($urandom_range(0, 255));
            divisor  = 8'(dsv);
            dividend = {8'(hv), 8'($urandom)};
            start    = 1'b1;
        end
        start = 1'b0;
        chk("rand_ops_done", int'(n_acc >= target), 1);
        repeat (N + 4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
